// File: rtl/mbr_parser.sv
// MBR parser: watches a 512-byte sector stream, checks the 0x55AA signature and extracts a FAT32 partition entry.
// Optional: define MBR_PARSER_PART_SCAN_EN to scan all four entries for the first FAT32 type (0x0B/0x0C).
module mbr_parser #(
  parameter int unsigned SECTOR_BYTES      = 512,
  parameter int unsigned PART_TABLE_OFFSET = 446
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_byte,
  input  logic        in_byte_valid,
  input  logic        in_block_done,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [7:0]  part_type,
  output logic [31:0] part_lba,
  output logic [31:0] part_sectors,
  output logic        err_sig,
  output logic        err_len,
  output logic        err_type
);

  localparam int unsigned CW = $clog2(SECTOR_BYTES + 1);
  localparam logic [CW-1:0] SB   = CW'(SECTOR_BYTES);
  localparam logic [CW-1:0] SIG0 = CW'(SECTOR_BYTES - 2);
  localparam logic [CW-1:0] SIG1 = CW'(SECTOR_BYTES - 1);
  localparam logic [CW-1:0] PTO  = CW'(PART_TABLE_OFFSET);
  localparam logic [CW-1:0] PTE  = CW'(PART_TABLE_OFFSET + 64);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [7:0]    r_sig0;
  logic [7:0]    r_sig1;
`ifdef MBR_PARSER_PART_SCAN_EN
  logic          r_found;
  logic [1:0]    r_sel;
`endif

  logic          w_take;
  logic          w_in_table;
  logic [5:0]    w_off;
  logic [1:0]    w_entry;
  logic [3:0]    w_k;
  logic          w_fat_type;
  logic          w_cap;
  logic          w_err_len;
  logic          w_err_sig;
  logic          w_err_type;

  assign w_take     = (r_state == S_COLLECT) && in_byte_valid && (r_count < SB);
  assign w_in_table = (r_count >= PTO) && (r_count < PTE);
  assign w_off      = 6'(r_count - PTO);
  assign w_entry    = w_off[5:4];
  assign w_k        = w_off[3:0];
  assign w_fat_type = (in_byte == 8'h0B) || (in_byte == 8'h0C);

  // Entry 0 stays selected until a FAT32 entry is found, so its fields are reported on a miss.
`ifdef MBR_PARSER_PART_SCAN_EN
  assign w_cap = w_in_table && ((r_found && (r_sel == w_entry)) || (!r_found && (w_entry == 2'd0)));
`else
  assign w_cap = w_in_table && (w_entry == 2'd0);
`endif

  assign w_err_len  = (r_count != SB);
  assign w_err_sig  = (r_sig0 != 8'h55) || (r_sig1 != 8'hAA);
  assign w_err_type = !((part_type == 8'h0B) || (part_type == 8'h0C));

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_sig0       <= '0;
      r_sig1       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      valid        <= 1'b0;
      part_type    <= '0;
      part_lba     <= '0;
      part_sectors <= '0;
      err_sig      <= 1'b0;
      err_len      <= 1'b0;
      err_type     <= 1'b0;
`ifdef MBR_PARSER_PART_SCAN_EN
      r_found      <= 1'b0;
      r_sel        <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_COLLECT;
            r_count      <= '0;
            r_sig0       <= '0;
            r_sig1       <= '0;
            busy         <= 1'b1;
            valid        <= 1'b0;
            part_type    <= '0;
            part_lba     <= '0;
            part_sectors <= '0;
            err_sig      <= 1'b0;
            err_len      <= 1'b0;
            err_type     <= 1'b0;
`ifdef MBR_PARSER_PART_SCAN_EN
            r_found      <= 1'b0;
            r_sel        <= '0;
`endif
          end
        end
        S_COLLECT: begin
          if (w_take) begin
            r_count <= r_count + CW'(1);
            if (r_count == SIG0) r_sig0 <= in_byte;
            if (r_count == SIG1) r_sig1 <= in_byte;
            if (w_in_table && (w_k == 4'd4)) begin
`ifdef MBR_PARSER_PART_SCAN_EN
              if (!r_found && (w_fat_type || (w_entry == 2'd0))) part_type <= in_byte;
              if (!r_found && w_fat_type) begin
                r_found <= 1'b1;
                r_sel   <= w_entry;
              end
`else
              if (w_entry == 2'd0) part_type <= in_byte;
`endif
            end
            if (w_cap && (w_k[3:2] == 2'b10)) part_lba[{w_k[1:0], 3'b000} +: 8] <= in_byte;
            if (w_cap && (w_k[3:2] == 2'b11)) part_sectors[{w_k[1:0], 3'b000} +: 8] <= in_byte;
          end
          if (in_block_done) r_state <= S_CHECK;
        end
        S_CHECK: begin
          err_len  <= w_err_len;
          err_sig  <= w_err_sig;
          err_type <= w_err_type;
          valid    <= !(w_err_len || w_err_sig || w_err_type);
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifndef MBR_PARSER_PART_SCAN_EN
  logic w_unused;
  assign w_unused = w_fat_type;
`endif

endmodule
